// File: rtl/game_pkg.sv
// Shared definitions for the player control path: command strobe bit
// positions, the projectile state encoding and a select-vector helper.
package game_pkg;

    localparam int CMD_W     = 5;
    localparam int CMD_LEFT  = 0;
    localparam int CMD_RIGHT = 1;
    localparam int CMD_AIM_L = 2;
    localparam int CMD_AIM_R = 3;
    localparam int CMD_SHOOT = 4;

    typedef enum logic [1:0] {
        SHOT_IDLE     = 2'd0,
        SHOT_FLIGHT   = 2'd1,
        SHOT_COOLDOWN = 2'd2
    } shot_state_e;

    // True when more than one command strobe is set in the same cycle.
    function automatic logic multi_hot(input logic [CMD_W-1:0] v);
        return (v & (v - CMD_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/shot_fsm.sv
// Single-projectile life cycle: IDLE -> FLIGHT -> COOLDOWN -> IDLE, with a
// shared down-counter and registered ready / shot_active / shot_done.
module shot_fsm
    import game_pkg::*;
#(
    parameter int FLIGHT_CYCLES   = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game_i,
    input  logic        shoot_i,
    output logic        ready_o,
    output logic        shot_active_o,
    output logic        shot_done_o,
    output shot_state_e state_o
);

    localparam int CNT_MAX = (FLIGHT_CYCLES > COOLDOWN_CYCLES) ? FLIGHT_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FLIGHT_LOAD   = CNT_W'(FLIGHT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    shot_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             active_q;
    logic             done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SHOT_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (new_game_i) begin
            // An aborted flight ends silently: no done pulse.
            state_q  <= SHOT_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SHOT_IDLE: begin
                    if (shoot_i) begin
                        state_q  <= SHOT_FLIGHT;
                        cnt_q    <= FLIGHT_LOAD;
                        ready_q  <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                SHOT_FLIGHT: begin
                    if (cnt_q == '0) begin
                        state_q  <= SHOT_COOLDOWN;
                        cnt_q    <= COOLDOWN_LOAD;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SHOT_COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_q <= SHOT_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= SHOT_IDLE;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign shot_active_o = active_q;
    assign shot_done_o   = done_q;
    assign state_o       = state_q;

endmodule

// File: rtl/player_state.sv
// Player position/aim tracking with saturation, one-hot command check and
// the fire-time shot latch; the projectile life cycle lives in shot_fsm.
module player_state
    import game_pkg::*;
#(
    parameter int X_W             = 5,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 31,
    parameter int X_INIT          = 16,
    parameter int AIM_W           = 3,
    parameter int AIM_INIT        = 4,
    parameter int FLIGHT_CYCLES   = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic [CMD_W-1:0] select,
    output logic [X_W-1:0]   pos_x,
    output logic [AIM_W-1:0] aim,
    output logic             ready,
    output logic             shot_active,
    output logic [X_W-1:0]   shot_x,
    output logic [AIM_W-1:0] shot_aim,
    output logic             shot_done,
    output logic             illegal
);

    localparam logic [X_W-1:0]   POS_MIN   = X_W'(X_MIN);
    localparam logic [X_W-1:0]   POS_MAX   = X_W'(X_MAX);
    localparam logic [X_W-1:0]   POS_INIT  = X_W'(X_INIT);
    localparam logic [AIM_W-1:0] AIM_MAX   = '1;
    localparam logic [AIM_W-1:0] AIM_RESET = AIM_W'(AIM_INIT);

    logic [X_W-1:0]   pos_q, pos_d;
    logic [AIM_W-1:0] aim_q, aim_d;
    logic [X_W-1:0]   sx_q, sx_d;
    logic [AIM_W-1:0] saim_q, saim_d;
    logic             illegal_q, illegal_d;

    logic        cmd_multi;
    logic        shoot_cmd;
    shot_state_e fsm_state;

    assign cmd_multi = multi_hot(select);
    assign shoot_cmd = !cmd_multi && select[CMD_SHOOT];

    shot_fsm #(
        .FLIGHT_CYCLES  (FLIGHT_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
    ) u_shot_fsm (
        .clk          (clk),
        .rst          (reset),
        .new_game_i   (new_game),
        .shoot_i      (shoot_cmd),
        .ready_o      (ready),
        .shot_active_o(shot_active),
        .shot_done_o  (shot_done),
        .state_o      (fsm_state)
    );

    always_comb begin
        pos_d     = pos_q;
        aim_d     = aim_q;
        sx_d      = sx_q;
        saim_d    = saim_q;
        illegal_d = 1'b0;
        if (new_game) begin
            // Shot latch deliberately survives a new game.
            pos_d = POS_INIT;
            aim_d = AIM_RESET;
        end else if (cmd_multi) begin
            illegal_d = 1'b1;
        end else begin
            if (select[CMD_LEFT] && pos_q > POS_MIN)
                pos_d = pos_q - 1'b1;
            if (select[CMD_RIGHT] && pos_q < POS_MAX)
                pos_d = pos_q + 1'b1;
            if (select[CMD_AIM_L] && aim_q != '0)
                aim_d = aim_q - 1'b1;
            if (select[CMD_AIM_R] && aim_q != AIM_MAX)
                aim_d = aim_q + 1'b1;
            if (shoot_cmd && fsm_state == SHOT_IDLE) begin
                sx_d   = pos_q;
                saim_d = aim_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q     <= POS_INIT;
            aim_q     <= AIM_RESET;
            sx_q      <= '0;
            saim_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            aim_q     <= aim_d;
            sx_q      <= sx_d;
            saim_q    <= saim_d;
            illegal_q <= illegal_d;
        end
    end

    assign pos_x    = pos_q;
    assign aim      = aim_q;
    assign shot_x   = sx_q;
    assign shot_aim = saim_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_player_state.sv
// Bench for player_state: directed scenarios plus random commands, with a
// timeline-based reference model feeding an expected-output queue.
module tb_player_state;
    import game_pkg::*;

    localparam int X_W      = 5;
    localparam int AIM_W    = 3;
    localparam int X_MIN    = 0;
    localparam int X_MAX    = 31;
    localparam int X_INIT   = 16;
    localparam int AIM_INIT = 4;
    localparam int AIM_TOP  = 7;
    localparam int F        = 16;
    localparam int C        = 8;
    localparam int EW       = 20;
    localparam int NONE     = -1000;

    localparam logic [4:0] S_LEFT  = 5'b00001;
    localparam logic [4:0] S_RIGHT = 5'b00010;
    localparam logic [4:0] S_AIM_L = 5'b00100;
    localparam logic [4:0] S_AIM_R = 5'b01000;
    localparam logic [4:0] S_SHOOT = 5'b10000;

    logic             clk = 1'b0;
    logic             reset;
    logic             new_game;
    logic [4:0]       select;
    logic [X_W-1:0]   pos_x;
    logic [AIM_W-1:0] aim;
    logic             ready;
    logic             shot_active;
    logic [X_W-1:0]   shot_x;
    logic [AIM_W-1:0] shot_aim;
    logic             shot_done;
    logic             illegal;

    // clock / reset
    always #5 clk = ~clk;

    player_state dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .select     (select),
        .pos_x      (pos_x),
        .aim        (aim),
        .ready      (ready),
        .shot_active(shot_active),
        .shot_x     (shot_x),
        .shot_aim   (shot_aim),
        .shot_done  (shot_done),
        .illegal    (illegal)
    );

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int shots_seen = 0;
    logic prev_active = 1'b0;

    int m_pos, m_aim, m_sx, m_saim, m_ill, m_edge, m_fire;

    function automatic logic [EW-1:0] pack(input int p, input int a, input bit rdy,
                                           input bit act, input int sx, input int sa,
                                           input bit dn, input bit il);
        return {X_W'(p), AIM_W'(a), rdy, act, X_W'(sx), AIM_W'(sa), dn, il};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    // Reference model: shot timing derived from edges elapsed since fire.
    task automatic model_edge(input logic [4:0] sel, input logic ng, input logic rst);
        int d;
        bit rdy_prev;
        if (rst) begin
            m_pos = X_INIT; m_aim = AIM_INIT; m_sx = 0; m_saim = 0; m_ill = 0; m_fire = NONE;
        end else if (ng) begin
            m_pos = X_INIT; m_aim = AIM_INIT; m_ill = 0; m_fire = NONE;
        end else begin
            rdy_prev = ((m_edge - 1) - m_fire) >= F + C;
            m_ill = ($countones(sel) > 1) ? 1 : 0;
            if ($countones(sel) == 1) begin
                if (sel == S_LEFT)  m_pos = (m_pos - 1 < X_MIN) ? X_MIN : m_pos - 1;
                if (sel == S_RIGHT) m_pos = (m_pos + 1 > X_MAX) ? X_MAX : m_pos + 1;
                if (sel == S_AIM_L) m_aim = (m_aim - 1 < 0) ? 0 : m_aim - 1;
                if (sel == S_AIM_R) m_aim = (m_aim + 1 > AIM_TOP) ? AIM_TOP : m_aim + 1;
                if (sel == S_SHOOT && rdy_prev) begin
                    m_sx = m_pos; m_saim = m_aim; m_fire = m_edge;
                end
            end
        end
        d = m_edge - m_fire;
        exp_q.push_back(pack(m_pos, m_aim, d >= F + C, d >= 0 && d < F,
                             m_sx, m_saim, d == F, m_ill != 0));
        m_edge++;
    endtask

    // driver
    task automatic step(input logic [4:0] sel, input logic ng);
        select   = sel;
        new_game = ng;
        @(posedge clk);
        model_edge(sel, ng, reset);
        #1;
        select   = '0;
        new_game = 1'b0;
    endtask

    task automatic repeat_step(input logic [4:0] sel, input int n);
        for (int i = 0; i < n; i++) step(sel, 1'b0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (shot_active && !prev_active) shots_seen++;
        prev_active = shot_active;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", pack(pos_x, aim, ready, shot_active, shot_x, shot_aim,
                                  shot_done, illegal), e);
        end
    end

    initial begin
        int shots0;
        int r;
        logic [4:0] sel;
        logic ng;
        reset = 1'b1; new_game = 1'b0; select = '0;
        m_edge = 0; m_fire = NONE;
        step(5'b0, 1'b0);
        step(5'b0, 1'b0);
        reset = 1'b0;
        step(5'b0, 1'b0);

        repeat_step(S_RIGHT, 20);
        step(5'b0, 1'b1);
        repeat_step(S_AIM_L, 5);
        step(S_AIM_R, 1'b0);
        step(5'b0, 1'b1);

        step(S_SHOOT, 1'b0);
        step(S_LEFT, 1'b0);
        repeat_step(5'b0, 30);

        shots0 = shots_seen;
        repeat_step(S_SHOOT, 30);
        repeat_step(5'b0, 30);
        check_int("shots_fired_in_burst", shots_seen - shots0, 2);

        step(5'b11111, 1'b0);
        step(5'b0, 1'b0);
        step(5'b00011, 1'b0);
        step(5'b0, 1'b0);

        step(S_SHOOT, 1'b0);
        repeat_step(5'b0, 4);
        step(S_RIGHT, 1'b1);
        repeat_step(5'b0, 30);

        // Async reset in the middle of cooldown, away from any clock edge.
        step(S_RIGHT, 1'b0);
        step(S_SHOOT, 1'b0);
        repeat_step(5'b0, 19);
        #1;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("async_reset", pack(pos_x, aim, ready, shot_active, shot_x, shot_aim,
                                  shot_done, illegal),
              pack(X_INIT, AIM_INIT, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0));
        step(5'b0, 1'b0);
        step(S_RIGHT, 1'b0);
        reset = 1'b0;
        step(5'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 11);
            if (r < 2) sel = '0;
            else if (r < 9) sel = 5'(1 << $urandom_range(0, 4));
            else if (r < 11) sel = 5'($urandom_range(0, 31));
            else sel = S_SHOOT;
            ng = ($urandom_range(0, 39) == 0);
            step(sel, ng);
        end

        step(5'b0, 1'b0);
        @(negedge clk);
        #1;
        check_int("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_state.md
# player_state

Consumer side of the player control path: takes the registered one-hot command strobes produced by the controls block and maintains the player's position and aim. It also runs the single-projectile life cycle (flight, then cooldown). It sits between the controls block and the renderer/collision logic. Every output it drives is registered.

## Interface
Parameters:
- X_W, 5: width of horizontal position and of shot_x.
- X_MIN, 0: leftmost legal position.
- X_MAX, 31: rightmost legal position. X_MIN < X_MAX < 2^X_W.
- X_INIT, 16: position after reset or new game.
- AIM_W, 3: aim angle width. Angle range is 0..2^AIM_W-1.
- AIM_INIT, 4: aim after reset or new game.
- FLIGHT_CYCLES, 16: projectile flight duration. Must be ≥1.
- COOLDOWN_CYCLES, 8: dead time after flight ends. Must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  synchronous restart strobe (start_new_game from controls).
- select  in  5  one-hot command strobe. Bit 0 = move left, 1 = move right, 2 = aim left, 3 = aim right, 4 = shoot. All-zero = no command.
- pos_x  out  X_W  current player position.
- aim  out  AIM_W  current aim angle.
- ready  out  1  high only in IDLE, meaning a shoot command will be accepted.
- shot_active  out  1  high while the projectile is in flight.
- shot_x  out  X_W  position latched at fire.
- shot_aim  out  AIM_W  aim latched at fire.
- shot_done  out  1  one-cycle pulse when flight ends.
- illegal  out  1  one-cycle pulse when select has more than one bit set.

## Operation
- Reset values: pos_x=X_INIT, aim=AIM_INIT, shot_x=0, shot_aim=0, FSM=IDLE, ready=1, shot_active=0, shot_done=0, illegal=0, counters=0.
- Command sampling: select is sampled on every rising clk edge.
- Invalid select: if more than one bit is set, the whole command is ignored and illegal pulses for one cycle.
- Move left: pos_x decrements by 1 and saturates at X_MIN.
- Move right: pos_x increments by 1 and saturates at X_MAX. There is no wrap-around.
- Aim left: aim decrements and saturates at 0.
- Aim right: aim increments and saturates at 2^AIM_W-1.
- Moving and aiming are allowed in every FSM state. They never affect a shot already in flight.
- Shoot in IDLE: accepted. shot_x and shot_aim load the current (pre-update) pos_x and aim, and the FSM goes to FLIGHT.
- Shoot outside IDLE: silently dropped. Shoot commands are not queued.
- FSM states are IDLE, FLIGHT and COOLDOWN:
  - IDLE→FLIGHT on an accepted shoot; the counter loads FLIGHT_CYCLES-1.
  - FLIGHT→COOLDOWN when the counter reaches 0; shot_done asserts in the first COOLDOWN cycle and the counter loads COOLDOWN_CYCLES-1.
  - COOLDOWN→IDLE when the counter reaches 0.
- new_game: takes priority over select in the same cycle. It restores all reset values except that shot_x and shot_aim hold their values. No shot_done is generated for an aborted flight.
- Reset asserted mid-flight: everything clears immediately (asynchronously), with no shot_done.

## Timing
- All outputs reflect a command one cycle after the edge that samples it.
- Shoot sampled at edge N, with parameter defaults:
  - shot_active high in cycles N+1..N+16.
  - shot_done high in cycle N+17 only.
  - ready low in cycles N+1..N+24, and high again at N+25.
- The earliest the next shoot can be accepted is edge N+25.
- illegal rises in the cycle after the offending sample.
- shot_done and illegal are never high for two consecutive cycles from a single event.

## Structure
- Shared package `game_pkg`:
  - command bit index constants: CMD_LEFT=0, CMD_RIGHT=1, CMD_AIM_L=2, CMD_AIM_R=3, CMD_SHOOT=4.
  - the 2-bit shot state enum (IDLE, FLIGHT, COOLDOWN).
  - The controls block imports the same constants.
- Sub-module `shot_fsm` holds the FSM, the down-counter, ready, shot_active and shot_done. The top level holds position/aim saturation, the one-hot check and the shot latch.

## Test plan
- Reset then 20× move right: pos_x goes 16→31 and holds at 31 after its 15th step; illegal stays 0.
- 5× aim left from reset: aim goes 4→0 and holds at 0. Then 1× aim right: aim=1.
- Shoot at edge N with pos_x=16 and aim=4, then move left at N+1:
  - shot_x=16 and shot_aim=4 stay stable.
  - shot_active is high exactly 16 cycles.
  - shot_done pulses at N+17.
  - ready returns at N+25.
- Shoot repeated every cycle for 30 cycles: exactly two shots fire, at edges N and N+25. All other shoot commands are dropped.
- select=5'b11111: no state change and a single illegal pulse. Then select=5'b00011: illegal pulses again and pos_x is unchanged.
- new_game at N+5 of a flight together with select=move right:
  - next cycle pos_x=16, aim=4, ready=1, shot_active=0.
  - shot_done never pulses.
- Async reset asserted mid-cooldown, between clock edges: outputs clear immediately.
